// File: rtl/xu_dispatch_if.sv
// xu_dispatch_if: bundle of the dispatcher's operand handshake, unit issue/result buses and retire handshake
// Ports (signals): in_valid/in_ready/in_sel/in_tag/in_op upstream handshake,
//   xu_en/xu_op/xu_stall issue to units, xu_res/xu_jump/xu_we unit results,
//   out_valid/out_ready/out_res/out_sel/out_tag/out_jump/out_we retire handshake.
// master = producer/units/consumer side, slave = dispatcher side.
interface xu_dispatch_if #(
    parameter int NUM_XU = 6,
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SEL_W = NUM_XU > 1 ? $clog2(NUM_XU) : 1;
    logic in_valid;
    logic in_ready;
    logic [SEL_W-1:0] in_sel;
    logic [TAG_W-1:0] in_tag;
    logic [3*WIDTH-1:0] in_op;
    logic [NUM_XU-1:0] xu_en;
    logic [NUM_XU*3*WIDTH-1:0] xu_op;
    logic xu_stall;
    logic [NUM_XU*2*WIDTH-1:0] xu_res;
    logic [NUM_XU-1:0] xu_jump;
    logic [NUM_XU-1:0] xu_we;
    logic out_valid;
    logic out_ready;
    logic [2*WIDTH-1:0] out_res;
    logic [SEL_W-1:0] out_sel;
    logic [TAG_W-1:0] out_tag;
    logic out_jump;
    logic out_we;
    modport master (
        output in_valid, in_sel, in_tag, in_op, xu_res, xu_jump, xu_we, out_ready,
        input in_ready, xu_en, xu_op, xu_stall, out_valid, out_res, out_sel, out_tag, out_jump, out_we
    );
    modport slave (
        input in_valid, in_sel, in_tag, in_op, xu_res, xu_jump, xu_we, out_ready,
        output in_ready, xu_en, xu_op, xu_stall, out_valid, out_res, out_sel, out_tag, out_jump, out_we
    );
endinterface

// File: rtl/xu_dispatch.sv
// xu_dispatch: issues one op per cycle to one of NUM_XU fixed-latency units and retires results in order
// Ports: clk, reset (sync, active-high), bus (xu_dispatch_if.slave: issue, unit and retire handshakes),
//   perf_issue/perf_kill per-unit issue and killed-op counters, present only when XU_PERF_CNT_EN is defined.
// A DEPTH-stage shadow pipeline of {valid, sel, tag} tracks each op alongside the units; a retiring taken
// jump invalidates every op whose tag differs from the retiring tag + 1.
module xu_dispatch #(
    parameter int NUM_XU = 6,
    parameter int DEPTH = 3,
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic reset,
    xu_dispatch_if.slave bus
`ifdef XU_PERF_CNT_EN
    ,
    output logic [NUM_XU*32-1:0] perf_issue,
    output logic [31:0] perf_kill
`endif
);
    localparam int SEL_W = NUM_XU > 1 ? $clog2(NUM_XU) : 1;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [SEL_W-1:0] s [DEPTH];
    logic [TAG_W-1:0] t [DEPTH];
    logic [NUM_XU-1:0] en;
    logic stall;
    logic issue;
    logic sel_ok;
    logic kill;
    logic [TAG_W-1:0] keep;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_sel = s[DEPTH-1];
    assign bus.out_tag = t[DEPTH-1];
    assign bus.in_ready = !stall;
    assign bus.xu_stall = stall;
    assign bus.xu_en = en;
    // Retire mux: results of the unit named by the last shadow stage, zero when that stage is empty.
    always_comb begin
        bus.out_res = '0;
        bus.out_jump = 1'b0;
        bus.out_we = 1'b0;
        for (int u = 0; u < NUM_XU; u++) begin
            if (v[DEPTH-1] && int'(s[DEPTH-1]) == u) begin
                bus.out_res = bus.xu_res[u*2*WIDTH +: 2*WIDTH];
                bus.out_jump = bus.xu_jump[u];
                bus.out_we = bus.xu_we[u];
            end
        end
    end
    always_comb begin
        stall = v[DEPTH-1] && !bus.out_ready;
        issue = bus.in_valid && !stall;
        sel_ok = int'(bus.in_sel) < NUM_XU;
        kill = v[DEPTH-1] && bus.out_ready && bus.out_jump;
        keep = bus.out_tag + TAG_W'(1);
        en = '0;
        bus.xu_op = '0;
        for (int u = 0; u < NUM_XU; u++) begin
            en[u] = issue && int'(bus.in_sel) == u;
            bus.xu_op[u*3*WIDTH +: 3*WIDTH] = en[u] ? bus.in_op : '0;
        end
        // The same keep filter applies to the op issuing this cycle and to every op advancing.
        v_nxt[0] = issue && sel_ok && !(kill && bus.in_tag != keep);
        for (int k = 1; k < DEPTH; k++) begin
            v_nxt[k] = v[k-1] && !(kill && t[k-1] != keep);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                s[k] <= '0;
                t[k] <= '0;
            end
        end else if (!stall) begin
            v <= v_nxt;
            s[0] <= bus.in_sel;
            t[0] <= bus.in_tag;
            for (int k = 1; k < DEPTH; k++) begin
                s[k] <= s[k-1];
                t[k] <= t[k-1];
            end
        end
    end
`ifdef XU_PERF_CNT_EN
    logic [31:0] kill_cnt;
    // An issue that does not land in stage 0 was either a bad select or a same-cycle kill.
    always_comb begin
        kill_cnt = 32'(issue && !v_nxt[0]);
        for (int k = 1; k < DEPTH; k++) begin
            kill_cnt = kill_cnt + 32'(v[k-1] && !v_nxt[k]);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issue <= '0;
            perf_kill <= '0;
        end else begin
            perf_kill <= perf_kill + kill_cnt;
            for (int u = 0; u < NUM_XU; u++) begin
                perf_issue[u*32 +: 32] <= perf_issue[u*32 +: 32] + 32'(en[u]);
            end
        end
    end
`endif
endmodule

// File: tb/tb_xu_dispatch.sv
// tb_xu_dispatch: directed vector table plus stall, kill, tag-wrap and mid-stream reset sequences
module tb_xu_dispatch;
    localparam int NX = 6;
    localparam int D = 3;
    localparam int W = 32;
    localparam int TW = 4;
    typedef struct {
        logic v;
        logic [2:0] sel;
        logic [3:0] tag;
        logic [95:0] op;
        logic [5:0] en;
        logic ov;
        logic [2:0] osel;
        logic [3:0] otag;
        logic [63:0] ores;
    } vec_t;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    vec_t tbl [15];
    logic [63:0] ures [NX][D];
    logic ujmp [NX][D];
    logic uwe [NX][D];
    xu_dispatch_if #(.NUM_XU(NX), .WIDTH(W), .TAG_W(TW)) bus ();
`ifdef XU_PERF_CNT_EN
    logic [NX*32-1:0] perf_issue;
    logic [31:0] perf_kill;
    logic [31:0] kpre;
`endif
    xu_dispatch #(.NUM_XU(NX), .DEPTH(D), .WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef XU_PERF_CNT_EN
        ,
        .perf_issue(perf_issue),
        .perf_kill(perf_kill)
`endif
    );
    always #5 clk = ~clk;
    // Unit model: res0 = opA+opB+u, res1 = opC^u, unit 3 jumps on opA[0], we = (opC != 0).
    always @(posedge clk) begin
        for (int u = 0; u < NX; u++) begin
            if (reset) begin
                for (int k = 0; k < D; k++) begin
                    ures[u][k] <= '0;
                    ujmp[u][k] <= 1'b0;
                    uwe[u][k] <= 1'b0;
                end
            end else if (!bus.xu_stall) begin
                ures[u][0] <= {bus.xu_op[u*96+64 +: 32] ^ 32'(u), bus.xu_op[u*96 +: 32] + bus.xu_op[u*96+32 +: 32] + 32'(u)};
                ujmp[u][0] <= (u == 3) && bus.xu_op[u*96];
                uwe[u][0] <= |bus.xu_op[u*96+64 +: 32];
                for (int k = 1; k < D; k++) begin
                    ures[u][k] <= ures[u][k-1];
                    ujmp[u][k] <= ujmp[u][k-1];
                    uwe[u][k] <= uwe[u][k-1];
                end
            end
        end
    end
    always_comb begin
        for (int u = 0; u < NX; u++) begin
            bus.xu_res[u*64 +: 64] = ures[u][D-1];
            bus.xu_jump[u] = ujmp[u][D-1];
            bus.xu_we[u] = uwe[u][D-1];
        end
    end
    function automatic logic [95:0] op3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {c, b, a};
    endfunction
    function automatic logic [63:0] r2(input logic [31:0] r1, input logic [31:0] r0);
        return {r1, r0};
    endfunction
    function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic [3:0] tag, input logic [95:0] op,
                                input logic [5:0] en, input logic ov, input logic [2:0] osel, input logic [3:0] otag,
                                input logic [63:0] ores);
        vec_t r;
        r.v = v; r.sel = sel; r.tag = tag; r.op = op; r.en = en;
        r.ov = ov; r.osel = osel; r.otag = otag; r.ores = ores;
        return r;
    endfunction
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask
    task automatic chk_op(input string name, input logic [5:0] en, input logic [95:0] op);
        logic [NX*96-1:0] exp;
        for (int u = 0; u < NX; u++) exp[u*96 +: 96] = en[u] ? op : '0;
        checks++;
        if (bus.xu_op !== exp) begin
            errors++;
            $display("FAIL %s xu_op got %h exp %h", name, bus.xu_op, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [2:0] sel, input logic [3:0] tag, input logic [95:0] op);
        bus.in_valid = v;
        bus.in_sel = sel;
        bus.in_tag = tag;
        bus.in_op = op;
    endtask
    task automatic check_reset(input string n);
        chk({n, " out_valid"}, 64'(bus.out_valid), 0);
        chk({n, " in_ready"}, 64'(bus.in_ready), 1);
        chk({n, " xu_en"}, 64'(bus.xu_en), 0);
        chk_op(n, 6'b0, 96'b0);
        chk({n, " out_res"}, bus.out_res, 0);
        chk({n, " out_jump"}, 64'(bus.out_jump), 0);
        chk({n, " out_we"}, 64'(bus.out_we), 0);
        chk({n, " out_sel"}, 64'(bus.out_sel), 0);
        chk({n, " out_tag"}, 64'(bus.out_tag), 0);
`ifdef XU_PERF_CNT_EN
        chk({n, " perf_kill"}, 64'(perf_kill), 0);
        for (int u = 0; u < NX; u++) chk({n, " perf_issue"}, 64'(perf_issue[u*32 +: 32]), 0);
`endif
    endtask
    // Branch on unit 3 with tag tb, two more tb ops behind it, then a tn op issued on the retire/kill cycle.
    task automatic kill_seq(input logic [3:0] tb, input logic [3:0] tn);
        drive(1, 3, tb, op3(1, 0, 0)); tick();
        drive(1, 0, tb, op3(0, 0, 0)); tick();
        drive(1, 1, tb, op3(0, 0, 0)); tick();
        drive(1, 2, tn, op3(50, 0, 0)); #1;
        chk("kill out_valid", 64'(bus.out_valid), 1);
        chk("kill out_sel", 64'(bus.out_sel), 3);
        chk("kill out_tag", 64'(bus.out_tag), 64'(tb));
        chk("kill out_jump", 64'(bus.out_jump), 1);
        chk("kill out_we", 64'(bus.out_we), 0);
        chk("kill xu_en", 64'(bus.xu_en), 64'b000100);
`ifdef XU_PERF_CNT_EN
        kpre = perf_kill;
`endif
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1 chk("killed out_valid", 64'(bus.out_valid), 0);
            tick();
        end
        #1;
        chk("kept out_valid", 64'(bus.out_valid), 1);
        chk("kept out_tag", 64'(bus.out_tag), 64'(tn));
        chk("kept out_sel", 64'(bus.out_sel), 2);
        chk("kept out_res", bus.out_res, r2(2, 52));
        chk("kept out_jump", 64'(bus.out_jump), 0);
`ifdef XU_PERF_CNT_EN
        chk("perf_kill delta", 64'(perf_kill - kpre), 2);
`endif
        tick();
        #1 chk("after kept out_valid", 64'(bus.out_valid), 0);
    endtask
    initial begin
        tbl[0] = mk(1, 0, 2, op3(7, 5, 0), 6'b000001, 0, 0, 0, 0);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3] = mk(0, 0, 0, 0, 0, 1, 0, 2, r2(0, 12));
        tbl[4] = mk(1, 0, 1, op3(1, 2, 3), 6'b000001, 0, 0, 0, 0);
        tbl[5] = mk(1, 1, 1, op3(20, 10, 0), 6'b000010, 0, 0, 0, 0);
        tbl[6] = mk(1, 2, 1, op3(1, 1, 7), 6'b000100, 0, 0, 0, 0);
        tbl[7] = mk(1, 3, 1, op3(2, 0, 0), 6'b001000, 1, 0, 1, r2(3, 3));
        tbl[8] = mk(0, 0, 0, 0, 0, 1, 1, 1, r2(1, 31));
        tbl[9] = mk(0, 0, 0, 0, 0, 1, 2, 1, r2(5, 4));
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 3, 1, r2(3, 5));
        tbl[11] = mk(1, 7, 0, op3(1, 1, 1), 6'b000000, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1 check_reset("init");
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].tag, tbl[i].op);
            #1;
            chk($sformatf("row%0d in_ready", i), 64'(bus.in_ready), 1);
            chk($sformatf("row%0d xu_stall", i), 64'(bus.xu_stall), 0);
            chk($sformatf("row%0d xu_en", i), 64'(bus.xu_en), 64'(tbl[i].en));
            chk_op($sformatf("row%0d", i), tbl[i].en, tbl[i].op);
            chk($sformatf("row%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
            chk($sformatf("row%0d out_res", i), bus.out_res, tbl[i].ores);
            chk($sformatf("row%0d out_jump", i), 64'(bus.out_jump), 0);
            if (tbl[i].ov) begin
                chk($sformatf("row%0d out_sel", i), 64'(bus.out_sel), 64'(tbl[i].osel));
                chk($sformatf("row%0d out_tag", i), 64'(bus.out_tag), 64'(tbl[i].otag));
            end
            tick();
        end
`ifdef XU_PERF_CNT_EN
        chk("perf_kill badsel", 64'(perf_kill), 1);
        chk("perf_issue u0", 64'(perf_issue[0 +: 32]), 2);
        chk("perf_issue u3", 64'(perf_issue[96 +: 32]), 1);
`endif
        drive(1, 0, 5, op3(100, 0, 0)); tick();
        drive(1, 1, 5, op3(200, 0, 9)); tick();
        drive(1, 2, 5, op3(300, 0, 0)); tick();
        drive(1, 4, 5, op3(1, 0, 0));
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall in_ready", 64'(bus.in_ready), 0);
            chk("stall xu_stall", 64'(bus.xu_stall), 1);
            chk("stall xu_en", 64'(bus.xu_en), 0);
            chk("stall out_valid", 64'(bus.out_valid), 1);
            chk("stall out_sel", 64'(bus.out_sel), 0);
            chk("stall out_res", bus.out_res, r2(0, 100));
            tick();
        end
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0);
        #1;
        chk("rel0 in_ready", 64'(bus.in_ready), 1);
        chk("rel0 out_sel", 64'(bus.out_sel), 0);
        chk("rel0 out_res", bus.out_res, r2(0, 100));
        tick();
        chk("rel1 out_valid", 64'(bus.out_valid), 1);
        chk("rel1 out_sel", 64'(bus.out_sel), 1);
        chk("rel1 out_res", bus.out_res, r2(8, 201));
        chk("rel1 out_we", 64'(bus.out_we), 1);
        tick();
        chk("rel2 out_valid", 64'(bus.out_valid), 1);
        chk("rel2 out_sel", 64'(bus.out_sel), 2);
        chk("rel2 out_res", bus.out_res, r2(2, 302));
        tick();
        chk("rel3 out_valid", 64'(bus.out_valid), 0);
        kill_seq(4'd4, 4'd5);
        kill_seq(4'd15, 4'd0);
        drive(1, 0, 1, op3(1, 1, 1)); tick();
        drive(1, 1, 1, op3(2, 2, 2)); tick();
        drive(1, 2, 1, op3(3, 3, 3)); tick();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 check_reset("midreset");
        for (int i = 0; i < 5; i++) begin
            chk("post-reset out_valid", 64'(bus.out_valid), 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
